// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Items shared by the AES-192 key-schedule blocks:
//   - schedule geometry constants (round keys, words, expansion iterations)
//   - initial round-constant word
//   - key-schedule controller state encoding
//   - xtime: multiply a GF(2^8) element by x (0x02)
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int          AES192_NUM_RK    = 13;
    localparam int          AES192_NUM_WORDS = 52;
    localparam int          AES192_NUM_ITER  = 8;
    localparam logic [31:0] RCON_INIT        = 32'h01000000;

    typedef enum logic {
        IDLE,
        EXPAND
    } ks_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/keyExpansion192.sv
// -----------------------------------------------------------------------------
// keyExpansion192
// Combinational AES-192 key-expansion step: turns six schedule words into
// the next six words.
// Ports:
//   key     in  192  current six words, word 0 at [191:160]
//   rcon    in  32   round constant word, byte in [31:24]
//   key_exp out 192  next six words, same word ordering as key
// -----------------------------------------------------------------------------
module keyExpansion192 (
    input  logic [191:0] key,
    input  logic [31:0]  rcon,
    output logic [191:0] key_exp
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [31:0] w_in  [6];
    logic [31:0] w_out [6];
    logic [31:0] rot_w;
    logic [31:0] sub_w;

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            w_in[k] = key[191 - 32*k -: 32];
        end
        // RotWord then SubWord on the last word of the previous group
        rot_w = {w_in[5][23:0], w_in[5][31:24]};
        sub_w = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]],
                 SBOX[rot_w[15:8]],  SBOX[rot_w[7:0]]};
        w_out[0] = w_in[0] ^ sub_w ^ rcon;
        for (int k = 1; k < 6; k++) begin
            w_out[k] = w_in[k] ^ w_out[k-1];
        end
        key_exp = {w_out[0], w_out[1], w_out[2], w_out[3], w_out[4], w_out[5]};
    end

endmodule

// File: rtl/key_schedule_ctrl_192.sv
// -----------------------------------------------------------------------------
// key_schedule_ctrl_192
// Runs keyExpansion192 for eight iterations after a key load, stores the
// 52-word AES-192 schedule and serves 128-bit round keys on a registered
// read port.
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous active-high reset
//   start      in   1    latch key_in and begin expansion (ignored while busy)
//   key_in     in   192  cipher key, word 0 at [191:160]
//   busy       out  1    expansion in progress
//   keys_valid out  1    full schedule stored
//   rd_en      in   1    round-key read request (honoured only when keys_valid)
//   rd_idx     in   4    round-key index 0..12; larger indices return zero
//   rk_out     out  128  registered round key, word 4i at [127:96]
//   rk_valid   out  1    one-cycle strobe after each accepted read
// -----------------------------------------------------------------------------
module key_schedule_ctrl_192
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [191:0] key_in,
    output logic         busy,
    output logic         keys_valid,
    input  logic         rd_en,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rk_out,
    output logic         rk_valid
);

    localparam int NUM_RK   = AES192_NUM_RK;
    localparam int NUM_ITER = AES192_NUM_ITER;

    localparam logic [3:0] LAST_RK_IDX = 4'(NUM_RK - 1);
    localparam logic [2:0] LAST_ITER   = 3'(NUM_ITER - 1);
    localparam logic [5:0] NUM_WORDS   = 6'(AES192_NUM_WORDS);

    ks_state_e     state_q,      state_d;
    logic [2:0]    iter_q,       iter_d;
    logic [31:0]   rcon_q,       rcon_d;
    logic [191:0]  cur_key_q,    cur_key_d;
    logic          busy_q,       busy_d;
    logic          keys_valid_q, keys_valid_d;
    logic [127:0]  rk_out_q,     rk_out_d;
    logic          rk_valid_q,   rk_valid_d;

    // Schedule storage; contents are only meaningful while keys_valid is set.
    logic [31:0]   key_buf_q [0:AES192_NUM_WORDS-1];

    logic [191:0]  key_exp;
    logic [191:0]  wr_key;
    logic [31:0]   wr_data [6];
    logic [5:0]    wr_base;
    logic [5:0]    wr_en;
    logic          wr_do;
    logic          start_accept;
    logic          rd_accept;
    logic [5:0]    rd_base;

    keyExpansion192 u_key_exp (
        .key     (cur_key_q),
        .rcon    (rcon_q),
        .key_exp (key_exp)
    );

    // Control FSM
    always_comb begin
        state_d      = state_q;
        iter_d       = iter_q;
        rcon_d       = rcon_q;
        cur_key_d    = cur_key_q;
        busy_d       = busy_q;
        keys_valid_d = keys_valid_q;
        start_accept = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    cur_key_d    = key_in;
                    rcon_d       = RCON_INIT;
                    iter_d       = 3'd0;
                    keys_valid_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = EXPAND;
                end
            end
            EXPAND: begin
                cur_key_d = key_exp;
                rcon_d    = {xtime(rcon_q[31:24]), 24'h000000};
                iter_d    = iter_q + 3'd1;
                if (iter_q == LAST_ITER) begin
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                    keys_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Buffer write port: the key itself on load, six expanded words per
    // iteration after that. The final iteration produces w48..w53 and only
    // the first four fit in the schedule.
    always_comb begin
        wr_do   = start_accept || (state_q == EXPAND);
        wr_key  = (state_q == EXPAND) ? key_exp : key_in;
        wr_base = (state_q == EXPAND) ? 6'(({3'b000, iter_q} + 6'd1) * 6'd6) : 6'd0;
        for (int k = 0; k < 6; k++) begin
            wr_data[k] = wr_key[191 - 32*k -: 32];
            wr_en[k]   = wr_do && ((wr_base + 6'(k)) < NUM_WORDS);
        end
    end

    // Read port
    always_comb begin
        rd_accept  = rd_en && keys_valid_q;
        rd_base    = {rd_idx, 2'b00};
        rk_out_d   = rk_out_q;
        rk_valid_d = 1'b0;
        if (rd_accept) begin
            rk_valid_d = 1'b1;
            if (rd_idx <= LAST_RK_IDX) begin
                rk_out_d = {key_buf_q[rd_base],
                            key_buf_q[rd_base + 6'd1],
                            key_buf_q[rd_base + 6'd2],
                            key_buf_q[rd_base + 6'd3]};
            end else begin
                rk_out_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            iter_q       <= 3'd0;
            rcon_q       <= RCON_INIT;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            rk_out_q     <= '0;
            rk_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            iter_q       <= iter_d;
            rcon_q       <= rcon_d;
            busy_q       <= busy_d;
            keys_valid_q <= keys_valid_d;
            rk_out_q     <= rk_out_d;
            rk_valid_q   <= rk_valid_d;
        end
    end

    // Working key needs no reset: it is always loaded before it is used.
    always_ff @(posedge clk) begin
        cur_key_q <= cur_key_d;
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 6; k++) begin
            if (wr_en[k]) begin
                key_buf_q[wr_base + 6'(k)] <= wr_data[k];
            end
        end
    end

    assign busy       = busy_q;
    assign keys_valid = keys_valid_q;
    assign rk_out     = rk_out_q;
    assign rk_valid   = rk_valid_q;

endmodule

// File: tb/tb_key_schedule_ctrl_192.sv
// -----------------------------------------------------------------------------
// tb_key_schedule_ctrl_192
// Self-checking bench for key_schedule_ctrl_192. The reference schedule is
// built from the textbook AES-192 key expansion with an S-box derived from
// GF(2^8) inversion plus the affine map.
// -----------------------------------------------------------------------------
module tb_key_schedule_ctrl_192;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [191:0] key_in;
    logic         busy;
    logic         keys_valid;
    logic         rd_en;
    logic [3:0]   rd_idx;
    logic [127:0] rk_out;
    logic         rk_valid;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [191:0] KEY_A2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

    logic [7:0]  sbox_m [256];
    logic [31:0] sched  [52];

    always #5 clk = ~clk;

    key_schedule_ctrl_192 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rk_out     (rk_out),
        .rk_valid   (rk_valid)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic build_model(input logic [191:0] key);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 6; i++) sched[i] = key[191 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 6; i < 52; i++) begin
            t = sched[i-1];
            if (i % 6 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            sched[i] = sched[i-6] ^ t;
        end
    endtask

    function automatic logic [127:0] rk_of(input int i);
        return {sched[4*i], sched[4*i+1], sched[4*i+2], sched[4*i+3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_kv(input int budget, output int n);
        n = 0;
        while (!keys_valid && n < budget) begin
            tick();
            n++;
        end
        if (!keys_valid) check("kv_timeout", 128'(keys_valid), 128'(1));
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 13; i++) begin
            rd_en  = 1'b1;
            rd_idx = 4'(i);
            tick();
            check($sformatf("%s_vld%0d", tag, i), 128'(rk_valid), 128'(1));
            check($sformatf("%s_rk%0d", tag, i), rk_out, rk_of(i));
        end
        rd_en = 1'b0;
    endtask

    initial begin
        int          n;
        logic [191:0] k_rand;
        logic [127:0] prev;
        logic         en;
        int           idx;

        init_sbox();
        rst = 1'b1; start = 1'b0; rd_en = 1'b0; rd_idx = '0; key_in = '0;
        repeat (3) tick();
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_kv", 128'(keys_valid), 128'(0));
        check("rst_rkv", 128'(rk_valid), 128'(0));
        check("rst_rkout", rk_out, 128'(0));

        // Reads before any schedule exists get no response
        rst = 1'b0; rd_en = 1'b1; rd_idx = 4'd0;
        tick(); tick();
        check("norsp_rkv", 128'(rk_valid), 128'(0));
        check("norsp_rkout", rk_out, 128'(0));
        rd_en = 1'b0;

        // FIPS-197 A.2 key: busy for exactly eight cycles, reads ignored meanwhile
        build_model(KEY_A2);
        start = 1'b1; key_in = KEY_A2;
        tick();
        start = 1'b0; rd_en = 1'b1; rd_idx = 4'd2;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("exp_busy%0d", c), 128'(busy), 128'(1));
            check($sformatf("exp_kv%0d", c), 128'(keys_valid), 128'(0));
            check($sformatf("exp_rkv%0d", c), 128'(rk_valid), 128'(0));
            tick();
        end
        check("done_busy", 128'(busy), 128'(0));
        check("done_kv", 128'(keys_valid), 128'(1));
        check("done_rkv", 128'(rk_valid), 128'(0));
        check("done_rkout", rk_out, 128'(0));

        // Back-to-back reads of every round key
        for (int i = 0; i < 13; i++) begin
            rd_en = 1'b1; rd_idx = 4'(i);
            tick();
            check($sformatf("b2b_vld%0d", i), 128'(rk_valid), 128'(1));
            check($sformatf("b2b_rk%0d", i), rk_out, rk_of(i));
            if (i == 0)  check("a2_rk0",  rk_out, 128'h8e73b0f7da0e6452c810f32b809079e5);
            if (i == 1)  check("a2_rk1",  rk_out, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
            if (i == 12) check("a2_rk12", rk_out, 128'he98ba06f448c773c8ecc720401002202);
        end
        rd_idx = 4'd13;
        tick();
        check("oob13_vld", 128'(rk_valid), 128'(1));
        check("oob13_rk", rk_out, 128'(0));
        rd_idx = 4'd15;
        tick();
        check("oob15_vld", 128'(rk_valid), 128'(1));
        check("oob15_rk", rk_out, 128'(0));

        // rk_out holds when nothing is read
        rd_idx = 4'd5;
        tick();
        rd_en = 1'b0;
        tick(); tick();
        check("hold_rkv", 128'(rk_valid), 128'(0));
        check("hold_rk", rk_out, rk_of(5));

        // Random read traffic
        prev = rk_of(5);
        for (int r = 0; r < 20; r++) begin
            en  = 1'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 15));
            rd_en = en; rd_idx = 4'(idx);
            tick();
            if (en) prev = (idx <= 12) ? rk_of(idx) : 128'(0);
            check($sformatf("rnd_vld%0d", r), 128'(rk_valid), 128'(en));
            check($sformatf("rnd_rk%0d", r), rk_out, prev);
        end
        rd_en = 1'b0;

        // Second start during expansion is ignored
        start = 1'b1; key_in = KEY_A2;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        tick();
        start = 1'b0;
        wait_kv(20, n);
        check("ign_latency", 128'(n), 128'(5));
        read_all("ign");

        // Reset in the middle of an expansion discards it
        start = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", 128'(busy), 128'(0));
        check("mrst_kv", 128'(keys_valid), 128'(0));
        rd_en = 1'b1; rd_idx = 4'd1;
        repeat (10) tick();
        rd_en = 1'b0;
        check("mrst_kv_late", 128'(keys_valid), 128'(0));
        check("mrst_rkv", 128'(rk_valid), 128'(0));
        check("mrst_rkout", rk_out, 128'(0));

        // All-zero key
        build_model(192'h0);
        start = 1'b1; key_in = '0;
        tick();
        start = 1'b0;
        wait_kv(20, n);
        check("zero_latency", 128'(n), 128'(8));
        rd_en = 1'b1; rd_idx = 4'd1;
        tick();
        rd_en = 1'b0;
        check("zero_rk1_lit", rk_out, 128'h00000000000000006263636362636363);
        check("zero_rk1_mdl", rk_out, rk_of(1));

        // Read and new start on the same edge: read sees the old schedule
        k_rand = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        rd_en = 1'b1; rd_idx = 4'd1; start = 1'b1; key_in = k_rand;
        tick();
        rd_en = 1'b0; start = 1'b0;
        check("rs_vld", 128'(rk_valid), 128'(1));
        check("rs_rk", rk_out, 128'h00000000000000006263636362636363);
        check("rs_kv", 128'(keys_valid), 128'(0));
        check("rs_busy", 128'(busy), 128'(1));
        build_model(k_rand);
        wait_kv(20, n);
        check("rs_latency", 128'(n), 128'(8));
        read_all("rs");

        // A few more random keys
        for (int t = 0; t < 3; t++) begin
            k_rand = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            build_model(k_rand);
            start = 1'b1; key_in = k_rand;
            tick();
            start = 1'b0;
            wait_kv(20, n);
            check($sformatf("rk%0d_latency", t), 128'(n), 128'(8));
            read_all($sformatf("rkey%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
